pcl_bitbang_mask: RTL and testbench



---
 rtl/pcl_bitbang_mask_pkg.sv | 48 ++++
 rtl/bb_pin_sync.sv | 24 ++
 rtl/pcl_bitbang_mask.sv | 230 +++++++++++++++++++++++
 tb/tb_pcl_bitbang_mask.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcl_bitbang_mask_pkg.sv
// Shared codes, state encodings and sizing helpers for the bit-bang GPIO protocol decoder.
package pcl_bitbang_mask_pkg;

    localparam logic [7:0] CMD_READ  = 8'h00;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_OK    = 8'h02;
    localparam logic [7:0] CMD_ECHO  = 8'h03;
    localparam logic [7:0] CMD_PING  = 8'h04;
    localparam logic [7:0] CMD_WMASK = 8'h05;
    localparam logic [7:0] CMD_RDREG = 8'h06;

    localparam logic [7:0] PAR_DIR   = 8'h00;
    localparam logic [7:0] PAR_OUT   = 8'h01;

    localparam logic [7:0] RPL_ERR   = 8'hFF;

    typedef enum logic [2:0] {
        ST_ARM,
        ST_WAIT_CMD,
        ST_WAIT_PARAM,
        ST_WAIT_MASK,
        ST_WAIT_DATA,
        ST_UPDATE,
        ST_WAIT_ECHO,
        ST_TX
    } state_t;

    // Where the bytes of the current reply come from.
    typedef enum logic [1:0] {
        TXS_ONE,
        TXS_PINS,
        TXS_DIR,
        TXS_OUT
    } tx_src_t;

    function automatic int unsigned num_bytes(input int unsigned io_num);
        return (io_num + 7) / 8;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

    function automatic logic param_valid(input logic [7:0] p);
        return (p == PAR_DIR) || (p == PAR_OUT);
    endfunction

endpackage

// File: rtl/bb_pin_sync.sv
// Per-bit multi-stage synchroniser for asynchronous pin inputs, cleared to 0 on reset.
module bb_pin_sync #(
    parameter int unsigned W      = 10,
    parameter int unsigned STAGES = 2
) (
    input  logic         in_clk,
    input  logic         in_rst,
    input  logic [W-1:0] pin_in,
    output logic [W-1:0] pin_sync
);

    logic [STAGES-1:0][W-1:0] sync_q;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pin_in};
        end
    end

    assign pin_sync = sync_q[STAGES-1];

endmodule

// File: rtl/pcl_bitbang_mask.sv
// Host-protocol decoder for bit-bang GPIO: masked writes, register read-back,
// synchronised pin sampling and error replies over a byte serial link.
module pcl_bitbang_mask
    import pcl_bitbang_mask_pkg::*;
#(
    parameter int unsigned IO_NUM_OF   = 10,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic [7:0]           data_rx,
    input  logic                 rx_done,
    output logic                 rx_trig,
    output logic [7:0]           data_tx,
    output logic                 tx_trig,
    input  logic                 tx_done,
    inout  wire  [IO_NUM_OF-1:0] io_pins
);

    localparam int unsigned N    = num_bytes(IO_NUM_OF);
    localparam int unsigned CW   = cnt_width(N);
    localparam int unsigned PW   = N * 8;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t               state;
    tx_src_t              tx_src;
    logic [7:0]           cmd;
    logic [7:0]           param;
    logic [CW-1:0]        byte_cnt;
    logic [IO_NUM_OF-1:0] direction;
    logic [IO_NUM_OF-1:0] outval;
    logic [IO_NUM_OF-1:0] stage_val;
    logic [IO_NUM_OF-1:0] stage_mask;
    logic [IO_NUM_OF-1:0] pins_sync;

    logic [PW-1:0]        src_val_c;
    logic [IO_NUM_OF-1:0] target_c;
    logic [IO_NUM_OF-1:0] new_reg_c;

    // Byte k of a zero-padded register image, counting from the most significant byte.
    function automatic logic [7:0] byte_sel(input logic [PW-1:0] v, input logic [CW-1:0] k);
        return 8'(v >> {LAST - k, 3'b000});
    endfunction

    bb_pin_sync #(
        .W      (IO_NUM_OF),
        .STAGES (SYNC_STAGES)
    ) u_pin_sync (
        .in_clk   (in_clk),
        .in_rst   (in_rst),
        .pin_in   (io_pins),
        .pin_sync (pins_sync)
    );

    for (genvar i = 0; i < IO_NUM_OF; i++) begin : g_pin
        assign io_pins[i] = direction[i] ? outval[i] : 1'bz;
    end

    // Multi-byte READ replies re-sample the synchroniser on every byte.
    always_comb begin
        src_val_c = '0;
        case (tx_src)
            TXS_PINS: src_val_c = PW'(pins_sync);
            TXS_DIR:  src_val_c = PW'(direction);
            TXS_OUT:  src_val_c = PW'(outval);
            default:  src_val_c = '0;
        endcase
    end

    always_comb begin
        target_c  = (param == PAR_DIR) ? direction : outval;
        new_reg_c = stage_val;
        if (cmd == CMD_WMASK) begin
            new_reg_c = (target_c & ~stage_mask) | (stage_val & stage_mask);
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state      <= ST_ARM;
            tx_src     <= TXS_ONE;
            cmd        <= '0;
            param      <= '0;
            byte_cnt   <= '0;
            direction  <= '0;
            outval     <= '0;
            stage_val  <= '0;
            stage_mask <= '0;
            rx_trig    <= 1'b0;
            tx_trig    <= 1'b0;
            data_tx    <= '0;
        end else begin
            rx_trig <= 1'b0;
            tx_trig <= 1'b0;
            case (state)
                ST_ARM: begin
                    rx_trig <= 1'b1;
                    state   <= ST_WAIT_CMD;
                end

                ST_WAIT_CMD: begin
                    if (rx_done) begin
                        cmd      <= data_rx;
                        byte_cnt <= '0;
                        case (data_rx)
                            CMD_READ: begin
                                data_tx <= byte_sel(PW'(pins_sync), '0);
                                tx_src  <= TXS_PINS;
                                tx_trig <= 1'b1;
                                state   <= ST_TX;
                            end
                            CMD_WRITE, CMD_WMASK, CMD_RDREG: begin
                                rx_trig <= 1'b1;
                                state   <= ST_WAIT_PARAM;
                            end
                            CMD_ECHO: begin
                                rx_trig <= 1'b1;
                                state   <= ST_WAIT_ECHO;
                            end
                            CMD_PING: begin
                                data_tx <= CMD_OK;
                                tx_src  <= TXS_ONE;
                                tx_trig <= 1'b1;
                                state   <= ST_TX;
                            end
                            default: begin
                                data_tx <= RPL_ERR;
                                tx_src  <= TXS_ONE;
                                tx_trig <= 1'b1;
                                state   <= ST_TX;
                            end
                        endcase
                    end
                end

                ST_WAIT_PARAM: begin
                    if (rx_done) begin
                        param <= data_rx;
                        if (cmd == CMD_RDREG) begin
                            tx_trig <= 1'b1;
                            state   <= ST_TX;
                            if (data_rx == PAR_DIR) begin
                                data_tx <= byte_sel(PW'(direction), '0);
                                tx_src  <= TXS_DIR;
                            end else if (data_rx == PAR_OUT) begin
                                data_tx <= byte_sel(PW'(outval), '0);
                                tx_src  <= TXS_OUT;
                            end else begin
                                data_tx <= RPL_ERR;
                                tx_src  <= TXS_ONE;
                            end
                        end else begin
                            stage_val  <= '0;
                            stage_mask <= '0;
                            rx_trig    <= 1'b1;
                            state      <= (cmd == CMD_WMASK) ? ST_WAIT_MASK : ST_WAIT_DATA;
                        end
                    end
                end

                // Bytes arrive MSB first; shifting left drops bits above the pin count.
                ST_WAIT_MASK: begin
                    if (rx_done) begin
                        stage_mask <= IO_NUM_OF'({stage_mask, data_rx});
                        rx_trig    <= 1'b1;
                        if (byte_cnt == LAST) begin
                            byte_cnt <= '0;
                            state    <= ST_WAIT_DATA;
                        end else begin
                            byte_cnt <= byte_cnt + CW'(1);
                        end
                    end
                end

                ST_WAIT_DATA: begin
                    if (rx_done) begin
                        stage_val <= IO_NUM_OF'({stage_val, data_rx});
                        if (byte_cnt == LAST) begin
                            byte_cnt <= '0;
                            state    <= ST_UPDATE;
                        end else begin
                            byte_cnt <= byte_cnt + CW'(1);
                            rx_trig  <= 1'b1;
                        end
                    end
                end

                ST_UPDATE: begin
                    tx_src  <= TXS_ONE;
                    tx_trig <= 1'b1;
                    state   <= ST_TX;
                    if (param_valid(param)) begin
                        if (param == PAR_DIR) begin
                            direction <= new_reg_c;
                        end else begin
                            outval <= new_reg_c;
                        end
                        data_tx <= CMD_OK;
                    end else begin
                        data_tx <= RPL_ERR;
                    end
                end

                ST_WAIT_ECHO: begin
                    if (rx_done) begin
                        data_tx <= data_rx;
                        tx_src  <= TXS_ONE;
                        tx_trig <= 1'b1;
                        state   <= ST_TX;
                    end
                end

                ST_TX: begin
                    if (tx_done) begin
                        if ((tx_src != TXS_ONE) && (byte_cnt != LAST)) begin
                            byte_cnt <= byte_cnt + CW'(1);
                            data_tx  <= byte_sel(src_val_c, byte_cnt + CW'(1));
                            tx_trig  <= 1'b1;
                        end else begin
                            state <= ST_ARM;
                        end
                    end
                end

                default: state <= ST_ARM;
            endcase
        end
    end

endmodule

// File: tb/tb_pcl_bitbang_mask.sv
// Scoreboard bench for pcl_bitbang_mask: a host driver feeds request bytes and queues
// hand-computed replies; an independent monitor plays the TX engine and checks replies.
module tb_pcl_bitbang_mask;

    logic       in_clk;
    logic       in_rst;
    logic [7:0] data_rx;
    logic       rx_done;
    logic       rx_trig;
    logic [7:0] data_tx;
    logic       tx_trig;
    logic       tx_done;
    wire  [9:0] io_pins;

    logic       tb_drv;
    logic [9:0] tb_pins;
    assign io_pins = tb_drv ? tb_pins : 10'bz;

    pcl_bitbang_mask #(
        .IO_NUM_OF   (10),
        .SYNC_STAGES (2)
    ) dut (
        .in_clk  (in_clk),
        .in_rst  (in_rst),
        .data_rx (data_rx),
        .rx_done (rx_done),
        .rx_trig (rx_trig),
        .data_tx (data_tx),
        .tx_trig (tx_trig),
        .tx_done (tx_done),
        .io_pins (io_pins)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    typedef struct {
        logic [7:0] b;
        int         lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   cyc;
    int   last_rx_cyc;
    int   arms;
    int   used;
    int   tx_seen;
    int   txd_cnt;

    always @(posedge in_clk) cyc <= cyc + 1;

    always @(negedge in_clk) if (rx_trig) arms = arms + 1;

    // Monitor: acts as the TX engine and pops the scoreboard on each tx_trig.
    always @(negedge in_clk) begin
        tx_done = 1'b0;
        if (txd_cnt > 0) begin
            txd_cnt = txd_cnt - 1;
            if (txd_cnt == 0) tx_done = 1'b1;
        end
        if (rx_trig && tx_trig) begin
            errors = errors + 1;
            $display("FAIL trig_overlap: rx_trig and tx_trig both 1 at cycle %0d, required not both", cyc);
        end
        if (tx_trig) begin
            tx_seen = tx_seen + 1;
            checks  = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_reply: got %02h, required no reply", data_tx);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (data_tx !== e.b) begin
                    errors = errors + 1;
                    $display("FAIL reply_byte: got %02h, required %02h", data_tx, e.b);
                end
                if (e.lat != 0) begin
                    checks = checks + 1;
                    if (cyc - last_rx_cyc != e.lat) begin
                        errors = errors + 1;
                        $display("FAIL reply_latency: got %0d, required %0d", cyc - last_rx_cyc, e.lat);
                    end
                end
            end
            txd_cnt = 4;
        end
    end

    task automatic expect_byte(input logic [7:0] b, input int lat);
        exp_t e;
        e.b   = b;
        e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] b);
        int t;
        t = 0;
        while (arms <= used && t < 300) begin
            @(negedge in_clk);
            t++;
        end
        if (arms <= used) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL rx_arm_timeout: no rx_trig for byte %02h, required one", b);
        end
        used = used + 1;
        repeat (2) @(negedge in_clk);
        data_rx     = b;
        rx_done     = 1'b1;
        last_rx_cyc = cyc;
        @(negedge in_clk);
        rx_done = 1'b0;
        data_rx = 8'h00;
    endtask

    task automatic check_val(input string name, input int got, input int want);
        checks = checks + 1;
        if (got != want) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    // Wait for all queued replies to drain, then confirm exactly one rearm pulse.
    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || txd_cnt != 0) && t < 500) begin
            @(negedge in_clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL reply_timeout: %0d replies outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (6) @(negedge in_clk);
        check_val("rearm_pulse", arms - used, 1);
    endtask

    initial begin
        int seen0;
        checks = 0; errors = 0; cyc = 0; last_rx_cyc = 0;
        arms = 0; used = 0; tx_seen = 0; txd_cnt = 0;
        in_rst = 1'b1; rx_done = 1'b0; data_rx = 8'h00; tx_done = 1'b0;
        tb_drv = 1'b1; tb_pins = 10'h155;

        // Reset state and single arm pulse after release.
        repeat (4) @(negedge in_clk);
        check_val("rst_rx_trig", int'(rx_trig), 0);
        check_val("rst_tx_trig", int'(tx_trig), 0);
        check_val("rst_data_tx", int'(data_tx), 0);
        in_rst = 1'b0;
        repeat (8) @(negedge in_clk);
        check_val("arm_once", arms, 1);
        check_val("no_tx_after_rst", tx_seen, 0);

        // Pins undriven by the DUT: READ sees the bench's pattern.
        expect_byte(8'h01, 1); expect_byte(8'h55, 0);
        send(8'h00);
        wait_idle();
        tb_drv = 1'b0;

        expect_byte(8'h02, 2);
        send(8'h01); send(8'h00); send(8'h03); send(8'hFF);
        wait_idle();
        check_val("pins_dir_set", int'(io_pins), 'h000);

        expect_byte(8'h02, 2);
        send(8'h01); send(8'h01); send(8'h02); send(8'hA5);
        wait_idle();
        check_val("pins_outval", int'(io_pins), 'h2A5);

        expect_byte(8'h02, 1); expect_byte(8'hA5, 0);
        send(8'h00);
        wait_idle();

        // Masked write touches only the low nibble.
        expect_byte(8'h02, 2);
        send(8'h05); send(8'h01); send(8'h00); send(8'h0F); send(8'h00); send(8'h0A);
        wait_idle();
        check_val("pins_wmask", int'(io_pins), 'h2AA);

        expect_byte(8'h02, 1); expect_byte(8'hAA, 0);
        send(8'h06); send(8'h01);
        wait_idle();
        expect_byte(8'h03, 1); expect_byte(8'hFF, 0);
        send(8'h06); send(8'h00);
        wait_idle();

        // Error replies.
        expect_byte(8'hFF, 1);
        send(8'h06); send(8'h07);
        wait_idle();
        expect_byte(8'hFF, 2);
        send(8'h01); send(8'h09); send(8'h12); send(8'h34);
        wait_idle();
        check_val("pins_bad_param", int'(io_pins), 'h2AA);
        expect_byte(8'hFF, 1);
        send(8'h42);
        wait_idle();

        // ECHO, then PING with a stray rx_done during its reply.
        expect_byte(8'h5A, 1);
        send(8'h03); send(8'h5A);
        wait_idle();
        seen0 = tx_seen;
        expect_byte(8'h02, 1);
        send(8'h04);
        for (int t = 0; t < 50 && tx_seen == seen0; t++) @(negedge in_clk);
        @(negedge in_clk);
        data_rx = 8'h03; rx_done = 1'b1;
        @(negedge in_clk);
        rx_done = 1'b0; data_rx = 8'h00;
        wait_idle();

        // Reset in the middle of a masked write.
        send(8'h05); send(8'h01); send(8'h00);
        repeat (3) @(negedge in_clk);
        seen0  = tx_seen;
        in_rst = 1'b1;
        used   = arms;
        tb_drv = 1'b1; tb_pins = 10'h0C3;
        repeat (3) @(negedge in_clk);
        check_val("midrst_data_tx", int'(data_tx), 0);
        check_val("midrst_rx_trig", int'(rx_trig), 0);
        in_rst = 1'b0;
        repeat (10) @(negedge in_clk);
        check_val("midrst_no_reply", tx_seen, seen0);
        check_val("midrst_rearm", arms - used, 1);

        expect_byte(8'h00, 1); expect_byte(8'hC3, 0);
        send(8'h00);
        wait_idle();
        tb_drv = 1'b0;
        expect_byte(8'h00, 1); expect_byte(8'h00, 0);
        send(8'h06); send(8'h01);
        wait_idle();
        expect_byte(8'h00, 1); expect_byte(8'h00, 0);
        send(8'h06); send(8'h00);
        wait_idle();
        expect_byte(8'h02, 1);
        send(8'h04);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
